// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle for the register scoreboard.
// Interface signal names are the scoreboard's own port names.
interface reg_scoreboard_if #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
);
  logic             issue_valid;
  logic             issue_long;
  logic             issue_rd_en;
  logic [4:0]       issue_rd_adr;
  logic [4:0]       rs1_adr;
  logic [4:0]       rs2_adr;
  logic             rs1_used;
  logic             rs2_used;
  logic             flush;
  logic             cmpl_valid;
  logic [4:0]       cmpl_rd_adr;
  logic             stall;
  logic [31:0]      pending;
  logic [CNT_W-1:0] outstanding;
  logic             full;
  logic             cmpl_err;

  modport master (
    output issue_valid, issue_long, issue_rd_en, issue_rd_adr,
           rs1_adr, rs2_adr, rs1_used, rs2_used, flush,
           cmpl_valid, cmpl_rd_adr,
    input  stall, pending, outstanding, full, cmpl_err
  );

  modport slave (
    input  issue_valid, issue_long, issue_rd_en, issue_rd_adr,
           rs1_adr, rs2_adr, rs1_used, rs2_used, flush,
           cmpl_valid, cmpl_rd_adr,
    output stall, pending, outstanding, full, cmpl_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight long-latency writes and stalls decode on RAW/WAW/capacity.
// Optional macro SB_CMPL_BYPASS_EN lets a same-cycle completion release its hazard combinationally.
module reg_scoreboard #(
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  reg_scoreboard_if.slave sb
);
  localparam int unsigned PTR_W = $clog2(MAX_OUT);

  logic [4:0]       fifo_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pending_q, pending_d;
  logic             err_q, err_d;

  logic        empty, full, pop, push, accept;
  logic        raw, waw, cap;
  logic [4:0]  head;
  logic [31:0] pend_eff;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(MAX_OUT));
  assign head  = fifo_q[rd_ptr_q];
  assign pop   = sb.cmpl_valid && !empty;

`ifdef SB_CMPL_BYPASS_EN
  // Completing head tag no longer blocks decode in its own cycle.
  assign pend_eff = pop ? (pending_q & ~(32'(1) << head)) : pending_q;
  assign cap      = sb.issue_long && full && !pop;
`else
  assign pend_eff = pending_q;
  assign cap      = sb.issue_long && full;
`endif

  assign raw = (sb.rs1_used && pend_eff[sb.rs1_adr]) ||
               (sb.rs2_used && pend_eff[sb.rs2_adr]);
  assign waw = sb.issue_rd_en && pend_eff[sb.issue_rd_adr];

  assign sb.stall = sb.issue_valid && !sb.flush && (raw || waw || cap);
  assign accept   = sb.issue_valid && !sb.flush && !sb.stall;
  assign push     = accept && sb.issue_long;

  // Next-state: clear on pop first so a same-register push wins.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    if (sb.cmpl_valid) begin
      if (empty || (sb.cmpl_rd_adr != head)) err_d = 1'b1;
    end
    if (pop) begin
      pending_d[head] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      if (sb.issue_rd_en && (sb.issue_rd_adr != 5'd0)) pending_d[sb.issue_rd_adr] = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_OUT); i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= sb.issue_rd_en ? sb.issue_rd_adr : 5'd0;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign sb.pending     = pending_q;
  assign sb.outstanding = cnt_q;
  assign sb.full        = full;
  assign sb.cmpl_err    = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with an in-order tag-queue reference model.
module tb_reg_scoreboard;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.MAX_OUT(MAX_OUT)) sbif ();
  reg_scoreboard #(.MAX_OUT(MAX_OUT)) dut (.clk(clk), .rst(rst), .sb(sbif.slave));

  logic [4:0]  exp_q [$];
  logic [31:0] m_pend;
  logic        m_err;
  int          checks = 0;
  int          errors = 0;
  logic        st;
  int          n_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sbif.issue_valid = 0; sbif.issue_long = 0; sbif.issue_rd_en = 0; sbif.issue_rd_adr = 0;
    sbif.rs1_adr = 0; sbif.rs2_adr = 0; sbif.rs1_used = 0; sbif.rs2_used = 0;
    sbif.flush = 0; sbif.cmpl_valid = 0; sbif.cmpl_rd_adr = 0;
  endtask

  task automatic iss(input logic lng, input logic en, input logic [4:0] rd);
    sbif.issue_valid = 1; sbif.issue_long = lng; sbif.issue_rd_en = en; sbif.issue_rd_adr = rd;
  endtask

  task automatic cmpl(input logic v, input logic [4:0] rd);
    sbif.cmpl_valid = v; sbif.cmpl_rd_adr = rd;
  endtask

  function automatic logic m_stall();
    logic [31:0] p;
    logic f;
    p = m_pend;
    f = (exp_q.size() == MAX_OUT);
`ifdef SB_CMPL_BYPASS_EN
    if (sbif.cmpl_valid && exp_q.size() != 0) begin
      p[exp_q[0]] = 1'b0;
      f = 1'b0;
    end
`endif
    return sbif.issue_valid && !sbif.flush &&
           ((sbif.rs1_used && p[sbif.rs1_adr]) || (sbif.rs2_used && p[sbif.rs2_adr]) ||
            (sbif.issue_rd_en && p[sbif.issue_rd_adr]) || (sbif.issue_long && f));
  endfunction

  // One clock: check stall mid-cycle, advance model, check registered state after the edge.
  task automatic cycle(output logic s);
    logic [4:0] h;
    logic acc;
    @(negedge clk);
    s = m_stall();
    chk("stall", 64'(sbif.stall), 64'(s));
    acc = sbif.issue_valid && !sbif.flush && !s;
    if (sbif.cmpl_valid) begin
      if (exp_q.size() == 0) m_err = 1'b1;
      else begin
        h = exp_q.pop_front();
        if (h != sbif.cmpl_rd_adr) m_err = 1'b1;
        m_pend[h] = 1'b0;
      end
    end
    if (acc && sbif.issue_long) begin
      exp_q.push_back(sbif.issue_rd_en ? sbif.issue_rd_adr : 5'd0);
      if (sbif.issue_rd_en && sbif.issue_rd_adr != 0) m_pend[sbif.issue_rd_adr] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("pending", 64'(sbif.pending), 64'(m_pend));
    chk("outstanding", 64'(sbif.outstanding), 64'(exp_q.size()));
    chk("full", 64'(sbif.full), 64'(exp_q.size() == MAX_OUT));
    chk("cmpl_err", 64'(sbif.cmpl_err), 64'(m_err));
  endtask

  initial begin
    clr();
    m_pend = '0;
    m_err  = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_pending", 64'(sbif.pending), 64'(0));
    chk("rst_outstanding", 64'(sbif.outstanding), 64'(0));
    chk("rst_full", 64'(sbif.full), 64'(0));
    chk("rst_err", 64'(sbif.cmpl_err), 64'(0));
    chk("rst_stall", 64'(sbif.stall), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use RAW
    iss(1, 1, 5); cycle(st);
    clr(); iss(0, 0, 0); sbif.rs1_adr = 5; sbif.rs1_used = 1;
    n_stall = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) cmpl(1, 5); else cmpl(0, 0);
      cycle(st);
      if (!st) break;
      n_stall++;
    end
`ifdef SB_CMPL_BYPASS_EN
    chk("loaduse_stalls", 64'(n_stall), 64'(2));
`else
    chk("loaduse_stalls", 64'(n_stall), 64'(3));
`endif
    chk("loaduse_p5", 64'(sbif.pending[5]), 64'(0));

    // Capacity
    clr();
    for (int r = 1; r <= 4; r++) begin
      iss(1, 1, 5'(r)); cycle(st);
    end
    chk("cap_full", 64'(sbif.full), 64'(1));
    chk("cap_out", 64'(sbif.outstanding), 64'(4));
    iss(1, 1, 6); cycle(st);
    chk("cap_stall", 64'(st), 64'(1));
    cmpl(1, 1); cycle(st);
    cmpl(0, 0);
`ifndef SB_CMPL_BYPASS_EN
    chk("cap_nobypass", 64'(st), 64'(1));
    cycle(st);
`endif
    chk("cap_accept", 64'(st), 64'(0));
    chk("cap_out4", 64'(sbif.outstanding), 64'(4));
    clr();
    cmpl(1, 2); cycle(st);
    cmpl(1, 3); cycle(st);
    cmpl(1, 4); cycle(st);
    cmpl(1, 6); cycle(st);
    clr();

    // x0 and unused sources
    iss(1, 1, 7); cycle(st);
    iss(1, 1, 0); sbif.rs1_adr = 0; sbif.rs1_used = 1; sbif.rs2_adr = 7; sbif.rs2_used = 0;
    cycle(st);
    chk("x0_stall", 64'(st), 64'(0));
    chk("x0_out", 64'(sbif.outstanding), 64'(2));
    clr();
    cmpl(1, 7); cycle(st);
    cmpl(1, 0); cycle(st);
    chk("x0_noerr", 64'(sbif.cmpl_err), 64'(0));
    chk("x0_pend", 64'(sbif.pending), 64'(0));

    // Flush and WAW
    clr(); iss(1, 1, 9); cycle(st);
    sbif.flush = 1; cycle(st);
    chk("flush_stall", 64'(st), 64'(0));
    chk("flush_nopush", 64'(sbif.outstanding), 64'(1));
    sbif.flush = 0; cycle(st);
    chk("waw_stall", 64'(st), 64'(1));
    cmpl(1, 9); cycle(st);
    cmpl(0, 0);
    if (st) cycle(st);
    chk("waw_accept", 64'(st), 64'(0));
    chk("waw_p9", 64'(sbif.pending[9]), 64'(1));
    clr(); cmpl(1, 9); cycle(st);

    // Errors
    clr(); cmpl(1, 1); cycle(st);
    chk("err_empty", 64'(sbif.cmpl_err), 64'(1));
    clr(); iss(1, 1, 2); cycle(st);
    iss(1, 1, 3); cycle(st);
    clr(); cmpl(1, 3); cycle(st);
    chk("err_p2", 64'(sbif.pending[2]), 64'(0));
    chk("err_p3", 64'(sbif.pending[3]), 64'(1));
    chk("err_sticky", 64'(sbif.cmpl_err), 64'(1));
    cmpl(1, 3); cycle(st);
    clr(); cycle(st);
    chk("err_sticky2", 64'(sbif.cmpl_err), 64'(1));

    // Async reset mid-operation
    iss(1, 1, 10); cycle(st);
    iss(1, 1, 11); cycle(st);
    iss(1, 1, 12); cycle(st);
    clr();
    chk("pre_rst_out", 64'(sbif.outstanding), 64'(3));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pending", 64'(sbif.pending), 64'(0));
    chk("arst_out", 64'(sbif.outstanding), 64'(0));
    chk("arst_err", 64'(sbif.cmpl_err), 64'(0));
    exp_q.delete();
    m_pend = '0;
    m_err  = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    iss(1, 1, 13); cycle(st);
    clr(); cmpl(1, 13); cycle(st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
